// File: rtl/neuron_sequencer_if.sv
// Spike event stream from the sequencer to the downstream consumer.
// Valid/ready handshake; spk_id is meaningful only while spk_valid is high.
interface neuron_sequencer_if #(
  parameter int ID_W = 2
) ();
  logic            spk_valid;
  logic            spk_ready;
  logic [ID_W-1:0] spk_id;

  modport master (output spk_valid, output spk_id, input spk_ready);
  modport slave  (input spk_valid, input spk_id, output spk_ready);
endinterface

// File: rtl/neuron_sequencer.sv
// Time-multiplexes one external neuron over N_NEURONS stored states, then streams spike ids.
// Timestep latency 2*N_NEURONS+1 cycles; each cycle spk_ready is low on a pending event adds one.
module neuron_sequencer #(
  parameter  int N_STAGE   = 2,
  parameter  int N_NEURONS = 4,
  parameter  int ID_W      = 2,
  localparam int WX        = 2**N_STAGE,
  localparam int UW        = N_STAGE + 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 clear,
  input  logic [WX-1:0]        x_in,
  input  logic [2:0]           shift_in,
  input  logic [UW-1:0]        minus_teta_in,
  input  logic                 w_wr_en,
  input  logic [ID_W-1:0]      w_wr_addr,
  input  logic [WX-1:0]        w_wr_data,
  output logic [WX-1:0]        nrn_w,
  output logic [WX-1:0]        nrn_x,
  output logic [2:0]           nrn_shift,
  output logic [UW-1:0]        nrn_previus_u,
  output logic [UW-1:0]        nrn_minus_teta,
  output logic                 nrn_was_spike,
  input  logic [UW-1:0]        nrn_u_out,
  input  logic                 nrn_is_spike,
  neuron_sequencer_if.master   spk,
  output logic [N_NEURONS-1:0] spike_vec,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {IDLE, EVAL, EMIT, DONE} state_t;

  localparam logic [ID_W:0]   N_LIM = (ID_W + 1)'(N_NEURONS);
  localparam logic [ID_W-1:0] LAST  = ID_W'(N_NEURONS - 1);

  state_t               state, state_d;
  logic [ID_W-1:0]      idx;
  logic [WX-1:0]        w_q [N_NEURONS];
  logic [UW-1:0]        u_q [N_NEURONS];
  logic [N_NEURONS-1:0] spk_q;
  logic [WX-1:0]        x_q;
  logic [2:0]           shift_q;
  logic [UW-1:0]        teta_q;
  logic                 last;
  logic                 emit_vld;
  logic                 emit_adv;
  logic                 wr_ok;

  assign last  = (idx == LAST);
  assign wr_ok = w_wr_en && ({1'b0, w_wr_addr} < N_LIM);

  assign nrn_w          = w_q[idx];
  assign nrn_x          = x_q;
  assign nrn_shift      = shift_q;
  assign nrn_previus_u  = u_q[idx];
  assign nrn_minus_teta = teta_q;
  assign nrn_was_spike  = spk_q[idx];

  assign spk.spk_valid = emit_vld;
  assign spk.spk_id    = idx;
  assign busy          = (state != IDLE);
  assign done          = (state == DONE);

  always_comb begin
    state_d  = state;
    emit_vld = 1'b0;
    emit_adv = 1'b0;
    unique case (state)
      IDLE: if (start && !clear) state_d = EVAL;
      EVAL: if (last) state_d = EMIT;
      EMIT: begin
        // Silent neurons are skipped without a handshake; spiking ones wait for ready.
        emit_vld = spk_q[idx];
        emit_adv = !spk_q[idx] || spk.spk_ready;
        if (emit_adv && last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      spk_q     <= '0;
      spike_vec <= '0;
      x_q       <= '0;
      shift_q   <= '0;
      teta_q    <= '0;
      for (int i = 0; i < N_NEURONS; i++) begin
        w_q[i] <= '0;
        u_q[i] <= '0;
      end
    end else begin
      state <= state_d;
      unique case (state)
        IDLE: begin
          if (wr_ok) w_q[w_wr_addr] <= w_wr_data;
          if (clear) begin
            spk_q <= '0;
            for (int i = 0; i < N_NEURONS; i++) u_q[i] <= '0;
          end else if (start) begin
            x_q     <= x_in;
            shift_q <= shift_in;
            teta_q  <= minus_teta_in;
            idx     <= '0;
          end
        end
        EVAL: begin
          u_q[idx]   <= nrn_u_out;
          spk_q[idx] <= nrn_is_spike;
          idx        <= last ? '0 : idx + ID_W'(1);
        end
        EMIT: begin
          if (emit_adv) begin
            idx <= last ? '0 : idx + ID_W'(1);
            // Publish on entry to DONE so spike_vec is valid alongside the done pulse.
            if (last) spike_vec <= spk_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_sequencer.sv
// Directed bench for neuron_sequencer with a weight-keyed neuron stub.
module tb_neuron_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, clear, w_wr_en;
  logic [3:0] x_in, w_wr_data;
  logic [2:0] shift_in;
  logic [3:0] minus_teta_in;
  logic [1:0] w_wr_addr;
  logic [3:0] nrn_w, nrn_x, nrn_previus_u, nrn_minus_teta, nrn_u_out;
  logic [2:0] nrn_shift;
  logic       nrn_was_spike, nrn_is_spike;
  logic [3:0] spike_vec;
  logic       busy, done;
  logic       stub_spk_en;
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [3:0] exp_x;
  logic [3:0] w_model [4] = '{4'b0011, 4'b0101, 4'b1111, 4'b0000};

  neuron_sequencer_if #(.ID_W(2)) spk_if ();

  neuron_sequencer #(.N_STAGE(2), .N_NEURONS(4), .ID_W(2)) dut (
    .clk(clk), .rst(rst), .start(start), .clear(clear),
    .x_in(x_in), .shift_in(shift_in), .minus_teta_in(minus_teta_in),
    .w_wr_en(w_wr_en), .w_wr_addr(w_wr_addr), .w_wr_data(w_wr_data),
    .nrn_w(nrn_w), .nrn_x(nrn_x), .nrn_shift(nrn_shift),
    .nrn_previus_u(nrn_previus_u), .nrn_minus_teta(nrn_minus_teta),
    .nrn_was_spike(nrn_was_spike), .nrn_u_out(nrn_u_out),
    .nrn_is_spike(nrn_is_spike), .spk(spk_if), .spike_vec(spike_vec),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Neuron stub: identifies the neuron by its (distinct) weight, returns u = id+1, spikes ids 1 and 3.
  int stub_id;
  always_comb begin
    case (nrn_w)
      4'b0011: stub_id = 0;
      4'b0101: stub_id = 1;
      4'b1111: stub_id = 2;
      default: stub_id = 3;
    endcase
    nrn_u_out    = 4'(stub_id + 1);
    nrn_is_spike = stub_spk_en && (stub_id == 1 || stub_id == 3);
  end

  typedef struct {
    logic       start, wr;
    logic [1:0] addr;
    logic [3:0] wdat;
    logic       rdy;
    logic       e_busy, e_done, e_vld;
    logic [1:0] e_id;
    logic [3:0] e_vec;
    logic       chk_n;
    logic [3:0] e_w, e_u;
    logic       e_ws;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_start(input logic [3:0] x);
    x_in = x; shift_in = 3'd5; minus_teta_in = 4'hC; start = 1'b1;
    exp_x = x;
    step();
    start = 1'b0; x_in = ~x; shift_in = 3'd0; minus_teta_in = 4'h0;
  endtask

  // Checks the four EVAL cycles (cycles 1..4) and returns at cycle 5.
  task automatic check_eval(input string tag, input bit u_zero, input logic [3:0] ws_exp, input bit w_zero);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_busy%0d", tag, i), busy, 1);
      check($sformatf("%s_w%0d", tag, i), nrn_w, w_zero ? 4'd0 : w_model[i]);
      check($sformatf("%s_u%0d", tag, i), nrn_previus_u, u_zero ? 4'd0 : 4'(i + 1));
      check($sformatf("%s_ws%0d", tag, i), nrn_was_spike, ws_exp[i]);
      if (i == 0) begin
        check($sformatf("%s_x", tag), nrn_x, exp_x);
        check($sformatf("%s_shift", tag), nrn_shift, 3'd5);
        check($sformatf("%s_teta", tag), nrn_minus_teta, 4'hC);
      end
      step();
    end
  endtask

  // Runs EMIT from cycle 5 until done; ready is low for stall_len cycles starting at stall_from.
  task automatic run_emit(input string tag, input int stall_from, input int stall_len, input logic [1:0] stall_id,
                          output int done_cyc, output int nvld, output logic [3:0] vec_at_done);
    done_cyc = -1; nvld = 0; vec_at_done = 'x;
    for (int c = 5; c < 40; c++) begin
      spk_if.spk_ready = !(c >= stall_from && c < stall_from + stall_len);
      if (spk_if.spk_valid) nvld++;
      if (!spk_if.spk_ready) begin
        check($sformatf("%s_hold_vld%0d", tag, c), spk_if.spk_valid, 1);
        check($sformatf("%s_hold_id%0d", tag, c), spk_if.spk_id, stall_id);
      end
      if (done) begin
        done_cyc = c; vec_at_done = spike_vec;
        step();
        break;
      end
      step();
    end
    spk_if.spk_ready = 1'b1;
    check($sformatf("%s_idle_after", tag), busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       tv [13];
    int         dc, nv;
    logic [3:0] vd;

    // start wr addr wdat rdy | busy done vld id vec | chk_n w u ws
    tv[0]  = '{0, 1, 2'd0, 4'b0011, 1, 0, 0, 0, 2'd0, 4'b0000, 0, 4'd0, 4'd0, 0};
    tv[1]  = '{0, 1, 2'd1, 4'b0101, 1, 0, 0, 0, 2'd0, 4'b0000, 0, 4'd0, 4'd0, 0};
    tv[2]  = '{0, 1, 2'd3, 4'b0000, 1, 0, 0, 0, 2'd0, 4'b0000, 0, 4'd0, 4'd0, 0};
    tv[3]  = '{1, 1, 2'd2, 4'b1111, 1, 1, 0, 0, 2'd0, 4'b0000, 1, 4'b0011, 4'd0, 0};
    tv[4]  = '{0, 0, 2'd0, 4'b0000, 1, 1, 0, 0, 2'd0, 4'b0000, 1, 4'b0101, 4'd0, 0};
    tv[5]  = '{0, 0, 2'd0, 4'b0000, 1, 1, 0, 0, 2'd0, 4'b0000, 1, 4'b1111, 4'd0, 0};
    tv[6]  = '{0, 0, 2'd0, 4'b0000, 1, 1, 0, 0, 2'd0, 4'b0000, 1, 4'b0000, 4'd0, 0};
    tv[7]  = '{0, 0, 2'd0, 4'b0000, 1, 1, 0, 0, 2'd0, 4'b0000, 0, 4'd0, 4'd0, 0};
    tv[8]  = '{0, 0, 2'd0, 4'b0000, 1, 1, 0, 1, 2'd1, 4'b0000, 0, 4'd0, 4'd0, 0};
    tv[9]  = '{0, 0, 2'd0, 4'b0000, 1, 1, 0, 0, 2'd0, 4'b0000, 0, 4'd0, 4'd0, 0};
    tv[10] = '{0, 0, 2'd0, 4'b0000, 1, 1, 0, 1, 2'd3, 4'b0000, 0, 4'd0, 4'd0, 0};
    tv[11] = '{0, 0, 2'd0, 4'b0000, 1, 1, 1, 0, 2'd0, 4'b1010, 0, 4'd0, 4'd0, 0};
    tv[12] = '{0, 0, 2'd0, 4'b0000, 1, 0, 0, 0, 2'd0, 4'b1010, 0, 4'd0, 4'd0, 0};

    rst = 1'b1; start = 1'b0; clear = 1'b0; w_wr_en = 1'b0; w_wr_addr = '0; w_wr_data = '0;
    x_in = 4'b1010; shift_in = 3'd5; minus_teta_in = 4'hC; exp_x = 4'b1010;
    spk_if.spk_ready = 1'b1; stub_spk_en = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_vld", spk_if.spk_valid, 0);
    check("rst_id", spk_if.spk_id, 0);
    check("rst_vec", spike_vec, 0);
    rst = 1'b0;
    step();

    // First timestep, with the last weight write coinciding with the accepted start.
    for (int i = 0; i < 13; i++) begin
      start = tv[i].start; w_wr_en = tv[i].wr; w_wr_addr = tv[i].addr; w_wr_data = tv[i].wdat;
      spk_if.spk_ready = tv[i].rdy;
      step();
      start = 1'b0; w_wr_en = 1'b0;
      check($sformatf("t%0d_busy", i), busy, tv[i].e_busy);
      check($sformatf("t%0d_done", i), done, tv[i].e_done);
      check($sformatf("t%0d_vld", i), spk_if.spk_valid, tv[i].e_vld);
      check($sformatf("t%0d_vec", i), spike_vec, tv[i].e_vec);
      if (tv[i].e_vld) check($sformatf("t%0d_id", i), spk_if.spk_id, tv[i].e_id);
      if (tv[i].chk_n) begin
        check($sformatf("t%0d_w", i), nrn_w, tv[i].e_w);
        check($sformatf("t%0d_u", i), nrn_previus_u, tv[i].e_u);
        check($sformatf("t%0d_ws", i), nrn_was_spike, tv[i].e_ws);
        check($sformatf("t%0d_x", i), nrn_x, 4'b1010);
      end
    end

    // Second timestep: stored state visible; consumer stalls 5 cycles on id 1.
    do_start(4'b0110);
    check_eval("ts2", 1'b0, 4'b1010, 1'b0);
    run_emit("ts2", 6, 5, 2'd1, dc, nv, vd);
    check("ts2_done_cyc", dc, 14);
    check("ts2_vec", vd, 4'b1010);

    // Third timestep: no spikes at all.
    stub_spk_en = 1'b0;
    do_start(4'b0001);
    check_eval("ts3", 1'b0, 4'b1010, 1'b0);
    run_emit("ts3", 0, 0, 2'd0, dc, nv, vd);
    check("ts3_done_cyc", dc, 9);
    check("ts3_nvld", nv, 0);
    check("ts3_vec", vd, 4'b0000);

    // Fourth timestep: start and weight write during EVAL must be ignored.
    stub_spk_en = 1'b1;
    do_start(4'b1100);
    start = 1'b1; w_wr_en = 1'b1; w_wr_addr = 2'd0; w_wr_data = 4'b1001;
    step();
    start = 1'b0; w_wr_en = 1'b0;
    check("ts4_w1", nrn_w, 4'b0101);
    repeat (3) step();
    run_emit("ts4", 0, 0, 2'd0, dc, nv, vd);
    check("ts4_done_cyc", dc, 9);
    check("ts4_nvld", nv, 2);

    // clear together with start: clear wins, start is dropped.
    clear = 1'b1; start = 1'b1;
    step();
    clear = 1'b0; start = 1'b0;
    check("clr_busy", busy, 0);
    do_start(4'b0011);
    check_eval("ts5", 1'b1, 4'b0000, 1'b0);

    // Reset while an event is pending in EMIT.
    spk_if.spk_ready = 1'b0;
    step();
    check("pre_rst_vld", spk_if.spk_valid, 1);
    check("pre_rst_vec", spike_vec, 4'b1010);
    #2 rst = 1'b1;
    #1;
    check("arst_vld", spk_if.spk_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_vec", spike_vec, 0);
    @(negedge clk);
    rst = 1'b0;
    spk_if.spk_ready = 1'b1;
    step();
    do_start(4'b1111);
    check_eval("ts6", 1'b1, 4'b0000, 1'b1);
    run_emit("ts6", 0, 0, 2'd0, dc, nv, vd);
    check("ts6_done_cyc", dc, 9);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/neuron_sequencer.md
Name: neuron_sequencer

Overview:
- Time-multiplexed driver for one combinational `neuron` instance (`N_STAGE` parameterised).
- Holds per-neuron weights, membrane potential and last-spike flag for `N_NEURONS` neurons.
- On each timestep it walks all neurons through the shared `neuron`, writes back `u_out`/`is_spike`, then streams spike events out on a valid/ready port.
- Sits between the input-spike source and the downstream spike consumer. The `neuron` is instantiated outside and connected via the `nrn_*` ports.

Parameters:
- N_STAGE, 2, neuron size. Weight/input width WX = 2**N_STAGE; potential width UW = N_STAGE+2.
- N_NEURONS, 4, number of neurons time-shared on one `neuron`.
- ID_W, 2, neuron index width; must satisfy 2**ID_W >= N_NEURONS.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, reset.
- start, input, 1, begin one timestep. Sampled only in IDLE.
- clear, input, 1, zero all potentials and spike flags. Sampled only in IDLE.
- x_in, input, WX, input spike vector; latched on accepted start.
- shift_in, input, 3, decay selector; latched on accepted start.
- minus_teta_in, input, UW, negated threshold; latched on accepted start.
- w_wr_en, input, 1, weight write strobe.
- w_wr_addr, input, ID_W, neuron index for weight write.
- w_wr_data, input, WX, weight vector.
- nrn_w, output, WX, weight of current neuron.
- nrn_x, output, WX, latched x.
- nrn_shift, output, 3, latched shift.
- nrn_previus_u, output, UW, stored potential of current neuron.
- nrn_minus_teta, output, UW, latched minus_teta.
- nrn_was_spike, output, 1, stored spike flag of current neuron.
- nrn_u_out, input, UW, neuron result.
- nrn_is_spike, input, 1, neuron result.
- spk_valid, output, 1, spike event valid.
- spk_ready, input, 1, consumer ready.
- spk_id, output, ID_W, index of spiking neuron.
- spike_vec, output, N_NEURONS, spike flags of the last completed timestep.
- busy, output, 1, high in any state other than IDLE.
- done, output, 1, one-cycle pulse at the end of a timestep.

Behaviour:
- Clocking and reset:
  - Single clock `clk`.
  - Reset `rst` is asynchronous and active-high.
  - On reset: state = IDLE; all weights, potentials and spike flags = 0; latched x/shift/minus_teta = 0; index = 0; `spk_valid` = 0, `spk_id` = 0, `busy` = 0, `done` = 0, `spike_vec` = 0.
  - Reset asserted mid-timestep aborts it immediately. No partial write-back survives.
- States: IDLE, EVAL, EMIT, DONE.
- IDLE:
  - `start` = 1 latches the inputs, sets index = 0, goes to EVAL.
  - `clear` = 1 zeroes potentials and spike flags (weights untouched).
  - `start` and `clear` both high: clear takes effect; start is ignored that cycle.
  - `start` is ignored outside IDLE.
- EVAL:
  - One neuron per cycle. `nrn_*` outputs are driven combinationally from index-selected storage.
  - At the clock edge, `nrn_u_out` and `nrn_is_spike` are written to `u[index]` and `spk[index]`; index increments.
  - After index N_NEURONS-1: index = 0, go to EMIT.
  - EVAL reads the pre-update values of neuron i only, so there are no read-after-write hazards.
- EMIT:
  - Scans index 0..N_NEURONS-1.
  - If `spk[index]` = 0: advance the same cycle, with `spk_valid` = 0.
  - If `spk[index]` = 1: `spk_valid` = 1, `spk_id` = index. Advance only on `spk_valid & spk_ready`.
  - `spk_valid` and `spk_id` stay stable while stalled. `spk_valid` never drops without a handshake.
  - After the last index: go to DONE.
- DONE:
  - `done` = 1 for exactly one cycle; `spike_vec` is updated to `spk[]` on that cycle; return to IDLE.
- Latency: with `spk_ready` held at 1 and start accepted at edge 0, `done` is high in cycle 2*N_NEURONS+1. Each stall cycle adds one.
- Weight writes:
  - Accepted only in IDLE; ignored when busy.
  - An out-of-range `w_wr_addr` (>= N_NEURONS) is ignored.
  - A weight write in the same cycle as an accepted start is performed.
- Arithmetic: the sequencer stores `nrn_u_out` verbatim (UW bits, no saturation or sign handling); all arithmetic lives in `neuron`.
- `nrn_*` outputs in IDLE/EMIT/DONE present neuron `index` but are don't-care.

Test Plan:
- Reset, then write weights 4'b0011, 4'b0101, 4'b1111, 4'b0000 to ids 0..3; neuron stub returns `u_out` = id+1 and `is_spike` = (id==1 or id==3); start with x = 4'b1010, `spk_ready` = 1 -> EVAL presents `nrn_w` in id order. Events `spk_id` = 1 then 3. `done` in cycle 9. `spike_vec` = 4'b1010.
- Second start with the same stub -> `nrn_previus_u` = 1,2,3,4 and `nrn_was_spike` = 0,1,0,1 in EVAL cycles.
- `spk_ready` = 0 for 5 cycles while `spk_id` = 1 is pending -> `spk_valid` and `spk_id` held constant; `done` delayed by 5 cycles (cycle 14).
- Stub returns no spikes -> `spk_valid` never asserts. `done` in cycle 9. `spike_vec` = 0.
- Pulse `start` and `w_wr_en` during EVAL -> both ignored. Then `clear` in IDLE -> next EVAL shows `nrn_previus_u` = 0 and `nrn_was_spike` = 0 for all neurons.
- Assert `rst` during EMIT with `spk_valid` = 1 -> `spk_valid`, `busy` and `spike_vec` drop to 0 immediately; after release, all potentials and weights read 0.
